add48_seq: RTL

Sequential multi-word adder controller. It adds two N_WORDS×12-bit operands by time-multiplexing one 12-bit carry-lookahead adder, processing one 12-bit word per cycle with the carry registered between passes. Operands enter through a valid/ready handshake, and the result comes back with a one-cycle done pulse. It sits between the arithmetic issue logic and the shared word adder, and is the only sequencer of that adder.

---
 rtl/add_seq_pkg.sv | 17 +
 rtl/adder_12b.sv | 50 +++++
 rtl/add48_seq.sv | 137 +++++++++++++
 3 files changed

// File: rtl/add_seq_pkg.sv
// Shared types and constants for the sequential word-serial adder.
package add_seq_pkg;

    localparam int unsigned WORD_W = 12;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    // Word index width; at least one bit so the counter is never zero-width.
    function automatic int unsigned idx_width(input int unsigned n_words);
        return (n_words > 1) ? $clog2(n_words) : 1;
    endfunction

endpackage

// File: rtl/adder_12b.sv
// 12-bit carry-lookahead adder: three 4-bit groups with a second lookahead level.
module adder_12b (
    input  logic [11:0] X,
    input  logic [11:0] Y,
    input  logic        Cin,
    output logic [11:0] S,
    output logic        Co
);

    logic [11:0] g;
    logic [11:0] p;
    logic [11:0] c;
    logic [2:0]  gg;
    logic [2:0]  pg;
    logic [3:0]  cg;

    always_comb begin
        g  = X & Y;
        p  = X ^ Y;
        gg = '0;
        pg = '0;
        c  = '0;
        for (int k = 0; k < 3; k++) begin
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            pg[k] = &p[4*k +: 4];
        end

        cg[0] = Cin;
        cg[1] = gg[0] | (pg[0] & Cin);
        cg[2] = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & Cin);
        cg[3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0])
              | (pg[2] & pg[1] & pg[0] & Cin);

        // In-group carries are expanded from each group's lookahead carry-in.
        for (int k = 0; k < 3; k++) begin
            c[4*k]   = cg[k];
            c[4*k+1] = g[4*k] | (p[4*k] & cg[k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & cg[k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & cg[k]);
        end

        S  = p ^ c;
        Co = cg[3];
    end

endmodule

// File: rtl/add48_seq.sv
// Word-serial multi-word adder: one shared 12-bit CLA, one word per cycle,
// carry registered between passes, valid/ready in and a one-cycle done pulse out.
module add48_seq
    import add_seq_pkg::*;
#(
    parameter int unsigned N_WORDS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_valid,
    output logic                      start_ready,
    input  logic [WORD_W*N_WORDS-1:0] A,
    input  logic [WORD_W*N_WORDS-1:0] B,
    input  logic                      Cin,
    output logic                      busy,
    output logic                      done,
    output logic [WORD_W*N_WORDS-1:0] Sum,
    output logic                      Co,
    output logic                      Ovf
);

    localparam int unsigned W    = WORD_W * N_WORDS;
    localparam int unsigned IdxW = idx_width(N_WORDS);

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic              carry_q, carry_d;
    logic [W-1:0]      a_q, a_d;
    logic [W-1:0]      b_q, b_d;
    logic [W-1:0]      sum_q, sum_d;
    logic              co_q, co_d;
    logic              ovf_q, ovf_d;

    logic [WORD_W-1:0] word_x;
    logic [WORD_W-1:0] word_y;
    logic [WORD_W-1:0] word_s;
    logic              word_co;
    logic              last_pass;

    // Operand word mux selected by the pass index.
    always_comb begin
        word_x = '0;
        word_y = '0;
        for (int i = 0; i < N_WORDS; i++) begin
            if (idx_q == IdxW'(i)) begin
                word_x = a_q[i*WORD_W +: WORD_W];
                word_y = b_q[i*WORD_W +: WORD_W];
            end
        end
    end

    adder_12b u_word_adder (
        .X   (word_x),
        .Y   (word_y),
        .Cin (carry_q),
        .S   (word_s),
        .Co  (word_co)
    );

    assign last_pass = (idx_q == IdxW'(N_WORDS - 1));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        co_d    = co_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            StIdle: begin
                if (start_valid) begin
                    a_d     = A;
                    b_d     = B;
                    carry_d = Cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                for (int i = 0; i < N_WORDS; i++) begin
                    if (idx_q == IdxW'(i)) begin
                        sum_d[i*WORD_W +: WORD_W] = word_s;
                    end
                end
                carry_d = word_co;
                if (last_pass) begin
                    co_d    = word_co;
                    // Carry into the MSB is recovered from the sum bit.
                    ovf_d   = word_x[WORD_W-1] ^ word_y[WORD_W-1] ^ word_s[WORD_W-1] ^ word_co;
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            co_q    <= co_d;
            ovf_q   <= ovf_d;
        end
    end

    assign start_ready = (state_q == StIdle);
    assign busy        = ~start_ready;
    assign done        = (state_q == StDone);
    assign Sum         = sum_q;
    assign Co          = co_q;
    assign Ovf         = ovf_q;

endmodule
